// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: sequential shift-add-3 binary-to-BCD conversion feeding a
// multiplexed active-low digit display. Define SSD_DP_EN to add the dp_mask/dp decimal-point path.
module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 13,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              signed_mode,
`ifdef SSD_DP_EN
    input  logic [DIGITS-1:0] dp_mask,
    output logic              dp,
`endif
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg
);

    localparam int NB = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int BW = 4 * NB;
    localparam int XD = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [3:0] SYM_DASH  = 4'hA;
    localparam logic [3:0] SYM_BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_UPD
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]      mag_q, mag_d;
    logic [BW-1:0]          bcd_q, bcd_d, bcd_adj;
    logic                   neg_q, neg_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic [DIGITS-1:0][3:0] disp_q, disp_d, disp_new;
    logic                   ovf_new;
    logic [4*XD-1:0]        bcd_x;
    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]             seg_q, seg_d;
`ifdef SSD_DP_EN
    logic                   dp_q, dp_d;
`endif

    function automatic logic [6:0] seg_code(input logic [3:0] sym);
        case (sym)
            4'd0:     seg_code = 7'b1000000;
            4'd1:     seg_code = 7'b1111001;
            4'd2:     seg_code = 7'b0100100;
            4'd3:     seg_code = 7'b0110000;
            4'd4:     seg_code = 7'b0011001;
            4'd5:     seg_code = 7'b0010010;
            4'd6:     seg_code = 7'b0000010;
            4'd7:     seg_code = 7'b1111000;
            4'd8:     seg_code = 7'b0000000;
            4'd9:     seg_code = 7'b0010000;
            SYM_DASH: seg_code = 7'b0111111;
            default:  seg_code = 7'b1111111;
        endcase
    endfunction

    // Symbolic display content derived from the finished BCD result; consumed only in S_UPD.
    always_comb begin
        int unsigned hi;
        int unsigned ovf_lim;
        bcd_x    = (4*XD)'(bcd_q);
        hi       = 0;
        ovf_new  = 1'b0;
        ovf_lim  = neg_q ? DIGITS - 1 : DIGITS;
        disp_new = '1;
        for (int unsigned i = 0; i < XD; i++) begin
            if (bcd_x[4*i +: 4] != 4'd0) begin
                hi = i;
                if (i >= ovf_lim) ovf_new = 1'b1;
            end
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (ovf_new)               disp_new[i] = SYM_DASH;
            else if (i <= hi)          disp_new[i] = bcd_x[4*i +: 4];
            else if (neg_q && i == hi + 1) disp_new[i] = SYM_DASH;
            else                       disp_new[i] = SYM_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (load && !busy_q) begin
                    if (signed_mode && data_in[DATA_W-1]) begin
                        mag_d = -data_in;
                        neg_d = 1'b1;
                    end else begin
                        mag_d = data_in;
                        neg_d = 1'b0;
                    end
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = BW'({bcd_adj, mag_q[DATA_W-1]});
                mag_d = {mag_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) state_d = S_UPD;
            end
            S_UPD: begin
                disp_d  = disp_new;
                ovf_d   = ovf_new;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan outputs are re-registered for the incoming digit on the same edge the index advances.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        anode_d = anode_q;
        seg_d   = seg_q;
`ifdef SSD_DP_EN
        dp_d    = dp_q;
`endif
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            anode_d = ~(DIGITS'(1) << idx_d);
            seg_d   = seg_code(disp_q[idx_d]);
`ifdef SSD_DP_EN
            dp_d    = ~dp_mask[idx_d];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                disp_q[i] <= (i == 0) ? 4'd0 : SYM_BLANK;
            end
            presc_q <= '0;
            idx_q   <= '0;
            anode_q <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg_q   <= 7'b1000000;
`ifdef SSD_DP_EN
            dp_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
`ifdef SSD_DP_EN
            dp_q    <= dp_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign anode    = anode_q;
    assign seg      = seg_q;
`ifdef SSD_DP_EN
    assign dp       = dp_q;
`endif

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIGITS=4, DATA_W=13, REFRESH_DIV=4.
module tb_ssd_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [12:0] data_in = '0;
    logic        signed_mode = 1'b0;
    logic        busy, overflow;
    logic [3:0]  anode;
    logic [6:0]  seg;
`ifdef SSD_DP_EN
    logic [3:0]  dp_mask = 4'b0100;
    logic        dp;
`endif

    int total = 0;
    int bad   = 0;

    ssd_scan_ctrl #(.DIGITS(4), .DATA_W(13), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .signed_mode(signed_mode),
`ifdef SSD_DP_EN
        .dp_mask    (dp_mask),
        .dp         (dp),
`endif
        .busy       (busy),
        .overflow   (overflow),
        .anode      (anode),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input logic [12:0] v, input logic sm, input bit guard, output int n);
        data_in     = v;
        signed_mode = sm;
        load        = 1'b1;
        tick();
        load = 1'b0;
        n    = 0;
        while (busy && n < 100) begin
            n++;
            if (guard && (n == 5 || n == 14)) begin
                load        = 1'b1;
                data_in     = 13'd42;
                signed_mode = 1'b0;
            end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic read_digit(input int d, output logic [6:0] s);
        logic [3:0] tgt;
        logic [3:0] prev;
        int k;
        tgt  = ~(4'b0001 << d);
        prev = anode;
        k    = 0;
        while (anode == prev && k < 50) begin
            tick();
            k++;
        end
        while (anode != tgt && k < 50) begin
            tick();
            k++;
        end
        check($sformatf("scan_wait_d%0d", d), 32'(k < 50), 32'd1);
        s = seg;
    endtask

    task automatic check_display(input string name, input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3, input logic ov);
        logic [6:0] exp_d[4];
        logic [6:0] s;
        exp_d = '{e0, e1, e2, e3};
        check({name, "_ovf"}, 32'(overflow), 32'(ov));
        for (int d = 0; d < 4; d++) begin
            read_digit(d, s);
            check($sformatf("%s_d%0d", name, d), 32'(s), 32'(exp_d[d]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int cnt;
        logic [3:0] cur;
        logic [3:0] seq[4];
        logic [6:0] s;

        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_anode", 32'(anode), 32'b1110);
        check("rst_seg", 32'(seg), 32'(S0));
        rst = 1'b1;
        tick();

        run_conv(13'd1234, 1'b0, 1'b0, n);
        check("busy_len_1234", 32'(n), 32'd14);
        check_display("u1234", S4, S3, S2, S1, 1'b0);

        run_conv(13'h1FF9, 1'b1, 1'b0, n);
        check_display("s_m7", S7, SD, SB, SB, 1'b0);

        run_conv(13'h1B2E, 1'b1, 1'b0, n);
        check_display("s_m1234", SD, SD, SD, SD, 1'b1);

        run_conv(13'h1C19, 1'b1, 1'b0, n);
        check_display("s_m999", S9, S9, S9, SD, 1'b0);

        run_conv(13'h1000, 1'b1, 1'b0, n);
        check("busy_len_m4096", 32'(n), 32'd14);
        check_display("s_m4096", SD, SD, SD, SD, 1'b1);

        run_conv(13'h1FFF, 1'b0, 1'b0, n);
        check_display("u8191", S1, S9, S1, S8, 1'b0);

        run_conv(13'h1FFF, 1'b1, 1'b0, n);
        check_display("s_m1", S1, SD, SB, SB, 1'b0);

        run_conv(13'd0, 1'b0, 1'b0, n);
        check_display("u0", S0, SB, SB, SB, 1'b0);

        run_conv(13'd1234, 1'b0, 1'b1, n);
        check("busy_len_guard", 32'(n), 32'd14);
        tick();
        check("guard_no_restart", 32'(busy), 32'd0);
        check_display("guard", S4, S3, S2, S1, 1'b0);

        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        k = 0;
        while (anode != 4'b0111 && k < 50) begin
            tick();
            k++;
        end
        while (anode == 4'b0111 && k < 50) begin
            tick();
            k++;
        end
        check("scan_start", 32'(anode), 32'b1110);
        for (int step = 0; step < 4; step++) begin
            cur = anode;
`ifdef SSD_DP_EN
            check($sformatf("dp_%0d", step), 32'(dp), 32'(cur != 4'b1011));
`endif
            cnt = 0;
            while (anode == cur && cnt < 50) begin
                tick();
                cnt++;
            end
            check($sformatf("scan_dwell_%0d", step), 32'(cnt), 32'd4);
            check($sformatf("scan_anode_%0d", step), 32'(anode), 32'(seq[step]));
        end

        run_conv(13'h1B2E, 1'b1, 1'b0, n);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        data_in     = 13'd1234;
        signed_mode = 1'b0;
        load        = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        check("conv_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        check("async_anode", 32'(anode), 32'b1110);
        check("async_seg", 32'(seg), 32'(S0));
        tick();
        tick();
        rst = 1'b1;
        repeat (20) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check_display("post_rst", S0, SB, SB, SB, 1'b0);
        read_digit(0, s);
        check("post_rst_d0_again", 32'(s), 32'(S0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
